// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: folds the core's inst and data SRAM ports onto one
// AXI3-subset master, one transaction at a time, data before inst.
module sram_axi_bridge #(
   parameter logic [3:0] INST_ID  = 4'd0,
   parameter logic [3:0] DATA_ID  = 4'd1,
   parameter bit         MAP_KSEG = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   output logic        wlast,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      IDLE, D_AR, D_R, D_AW, D_B, I_AR, I_R, DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:2] iaddr_q, iaddr_d;
   logic [31:0] daddr_q, daddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wen_q, wen_d;
   logic        pend_d_q, pend_d_d;
   logic        pend_i_q, pend_i_d;
   logic [31:0] irdata_q, irdata_d;
   logic [31:0] drdata_q, drdata_d;
   logic        aw_ok_q, aw_ok_d;
   logic        w_ok_q, w_ok_d;
   logic        any_en;

   function automatic logic [31:0] map_addr(input logic [31:0] a);
      if (MAP_KSEG && (a[31:29] == 3'b100 || a[31:29] == 3'b101))
         return {3'b000, a[28:0]};
      return a;
   endfunction

   assign any_en  = inst_sram_en | data_sram_en;
   assign arlen   = 4'd0;
   assign arburst = 2'b01;
   assign awlen   = 4'd0;
   assign wlast   = 1'b1;

   assign inst_sram_rdata = irdata_q;
   assign data_sram_rdata = drdata_q;

   // Payloads come straight from latched registers so they hold while valid is up.
   assign arid   = (state_q == I_AR) ? INST_ID : DATA_ID;
   assign araddr = (state_q == I_AR) ? {iaddr_q, 2'b00}
                                     : {daddr_q[31:2], 2'b00};
   assign arsize = 3'd2;
   assign awid   = DATA_ID;
   assign awaddr = daddr_q;
   assign wdata  = wdata_q;
   assign wstrb  = wen_q;

   // Transfer size derived from the byte-enable pattern.
   always_comb begin
      unique case (wen_q)
         4'b1111:         awsize = 3'd2;
         4'b0011, 4'b1100: awsize = 3'd1;
         default:         awsize = 3'd0;
      endcase
   end

   // Freeze the pipeline until the current cycle's requests are all served.
   assign stallreq = rst && (state_q != DONE) && !(state_q == IDLE && !any_en);

   // Next-state, capture and handshake outputs.
   always_comb begin
      state_d  = state_q;
      iaddr_d  = iaddr_q;
      daddr_d  = daddr_q;
      wdata_d  = wdata_q;
      wen_d    = wen_q;
      pend_d_d = pend_d_q;
      pend_i_d = pend_i_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      aw_ok_d  = aw_ok_q;
      w_ok_d   = w_ok_q;
      arvalid  = 1'b0;
      rready   = 1'b0;
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      bready   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_en) begin
               iaddr_d  = map_addr(inst_sram_addr) >> 2;
               daddr_d  = map_addr(data_sram_addr);
               wdata_d  = data_sram_wdata;
               wen_d    = data_sram_wen;
               pend_d_d = data_sram_en;
               pend_i_d = inst_sram_en;
               aw_ok_d  = 1'b0;
               w_ok_d   = 1'b0;
               if (data_sram_en)
                  state_d = (data_sram_wen != 4'd0) ? D_AW : D_AR;
               else
                  state_d = I_AR;
            end
         end
         D_AR: begin
            arvalid = 1'b1;
            if (arready) state_d = D_R;
         end
         D_R: begin
            rready = 1'b1;
            if (rvalid && rid == DATA_ID && pend_d_q) begin
               drdata_d = rdata;
               pend_d_d = 1'b0;
               state_d  = pend_i_q ? I_AR : DONE;
            end
         end
         D_AW: begin
            awvalid = !aw_ok_q;
            wvalid  = !w_ok_q;
            if (awready) aw_ok_d = 1'b1;
            if (wready)  w_ok_d  = 1'b1;
            if ((aw_ok_q || awready) && (w_ok_q || wready))
               state_d = D_B;
         end
         D_B: begin
            bready = 1'b1;
            if (bvalid) begin
               pend_d_d = 1'b0;
               state_d  = pend_i_q ? I_AR : DONE;
            end
         end
         I_AR: begin
            arvalid = 1'b1;
            if (arready) state_d = I_R;
         end
         I_R: begin
            rready = 1'b1;
            if (rvalid && rid == INST_ID) begin
               irdata_d = rdata;
               pend_i_d = 1'b0;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops every valid/ready at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         iaddr_q  <= '0;
         daddr_q  <= '0;
         wdata_q  <= '0;
         wen_q    <= '0;
         pend_d_q <= 1'b0;
         pend_i_q <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
         aw_ok_q  <= 1'b0;
         w_ok_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         iaddr_q  <= iaddr_d;
         daddr_q  <= daddr_d;
         wdata_q  <= wdata_d;
         wen_q    <= wen_d;
         pend_d_q <= pend_d_d;
         pend_i_q <= pend_i_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         aw_ok_q  <= aw_ok_d;
         w_ok_q   <= w_ok_d;
      end
   end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed stimulus with queued expectations,
// checked by an independent negedge monitor.
module tb_sram_axi_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_sram_en = 1'b0;
   logic [31:0] inst_sram_addr = '0;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en = 1'b0;
   logic [3:0]  data_sram_wen = '0;
   logic [31:0] data_sram_addr = '0;
   logic [31:0] data_sram_wdata = '0;
   logic [31:0] data_sram_rdata;
   logic        stallreq;
   logic [3:0]  arid, arlen, awid, awlen, rid = '0, wstrb;
   logic [31:0] araddr, awaddr, wdata, rdata = '0;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst;
   logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
   logic        awvalid, awready = 1'b0, wvalid, wlast, wready = 1'b0;
   logic        bvalid = 1'b0, bready;

   sram_axi_bridge dut (
      .clk(clk), .rst(rst),
      .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
      .inst_sram_rdata(inst_sram_rdata),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast),
      .wready(wready), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } a_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
   typedef struct { logic [31:0] i; logic [31:0] d; } d_t;

   a_t ar_q[$];
   a_t aw_q[$];
   w_t w_q[$];
   d_t done_q[$];

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [31:0] exp_i = '0;
   logic [31:0] exp_d = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT completes a handshake or a DONE cycle.
   always @(negedge clk) begin
      if (rst) begin
         if (arvalid && arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
            else begin
               a_t e;
               e = ar_q.pop_front();
               chk("arid", {28'd0, arid}, {28'd0, e.id});
               chk("araddr", araddr, e.addr);
               chk("arsize", {29'd0, arsize}, {29'd0, e.size});
               chk("arlen", {28'd0, arlen}, 0);
            end
         end
         if (awvalid && awready) begin
            if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
               a_t e;
               e = aw_q.pop_front();
               chk("awid", {28'd0, awid}, {28'd0, e.id});
               chk("awaddr", awaddr, e.addr);
               chk("awsize", {29'd0, awsize}, {29'd0, e.size});
            end
         end
         if (wvalid && wready) begin
            if (w_q.size() == 0) chk("w_unexpected", 1, 0);
            else begin
               w_t e;
               e = w_q.pop_front();
               chk("wdata", wdata, e.data);
               chk("wstrb", {28'd0, wstrb}, {28'd0, e.strb});
               chk("wlast", {31'd0, wlast}, 1);
            end
         end
         if ((inst_sram_en || data_sram_en) && !stallreq) begin
            done_cnt++;
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               d_t e;
               e = done_q.pop_front();
               chk("inst_rdata", inst_sram_rdata, e.i);
               chk("data_rdata", data_sram_rdata, e.d);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic cond(input int w);
      case (w)
         0:       return arvalid;
         1:       return rready;
         2:       return awvalid | wvalid;
         3:       return bready;
         default: return !stallreq;
      endcase
   endfunction

   task automatic wait_for(input int w, input string nm);
      int n = 0;
      while (!cond(w) && n < 100) begin
         step();
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("FAIL timeout %s: waited %0d cycles, required under 100", nm, n);
      end
   endtask

   task automatic ar_accept(input int dly);
      logic [31:0] a0;
      wait_for(0, "arvalid");
      a0 = araddr;
      for (int c = 0; c < dly; c++) begin
         step();
         chk("arvalid_hold", {31'd0, arvalid}, 1);
         chk("araddr_hold", araddr, a0);
         chk("stall_hold", {31'd0, stallreq}, 1);
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
   endtask

   task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
      wait_for(1, "rready");
      rvalid = 1'b1;
      rid = id;
      rdata = d;
      step();
      rvalid = 1'b0;
   endtask

   task automatic wr_accept(input int aw_dly, input int w_dly);
      int mx;
      mx = (aw_dly > w_dly) ? aw_dly : w_dly;
      wait_for(2, "awvalid");
      for (int c = 0; c <= mx; c++) begin
         awready = (c == aw_dly);
         wready = (c == w_dly);
         chk("awvalid_hold", {31'd0, awvalid}, {31'd0, c <= aw_dly});
         chk("wvalid_hold", {31'd0, wvalid}, {31'd0, c <= w_dly});
         chk("bready_early", {31'd0, bready}, 0);
         step();
      end
      awready = 1'b0;
      wready = 1'b0;
   endtask

   task automatic b_resp();
      wait_for(3, "bready");
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
   endtask

   task automatic finish_txn();
      wait_for(4, "done");
      step();
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      data_sram_wen = 4'd0;
      step();
   endtask

   task automatic fetch(input logic [31:0] a);
      inst_sram_en = 1'b1;
      inst_sram_addr = a;
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] wen,
                        input logic [31:0] d);
      data_sram_en = 1'b1;
      data_sram_wen = wen;
      data_sram_addr = a;
      data_sram_wdata = d;
   endtask

   initial begin
      int d0;
      step();
      chk("rst_stall", {31'd0, stallreq}, 0);
      chk("rst_arvalid", {31'd0, arvalid}, 0);
      step();
      rst = 1'b1;
      step();
      chk("idle_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 0);
      chk("idle_stall", {31'd0, stallreq}, 0);
      chk("rst_irdata", inst_sram_rdata, 0);
      chk("rst_drdata", data_sram_rdata, 0);

      // inst-only fetch through kseg1
      fetch(32'hBFC00000);
      #1 chk("idle_stall_comb", {31'd0, stallreq}, 1);
      ar_q.push_back('{4'd0, 32'h1FC00000, 3'd2});
      exp_i = 32'h3C1D0001;
      done_q.push_back('{exp_i, exp_d});
      ar_accept(1);
      r_beat(4'd0, 32'h3C1D0001);
      finish_txn();

      // load and fetch together: data first
      fetch(32'hBFC00004);
      data_sram_en = 1'b1;
      data_sram_wen = 4'd0;
      data_sram_addr = 32'h80001000;
      ar_q.push_back('{4'd1, 32'h00001000, 3'd2});
      ar_q.push_back('{4'd0, 32'h1FC00004, 3'd2});
      exp_i = 32'h11112222;
      exp_d = 32'hDEADBEEF;
      done_q.push_back('{exp_i, exp_d});
      d0 = done_cnt;
      ar_accept(0);
      r_beat(4'd1, 32'hDEADBEEF);
      ar_accept(0);
      r_beat(4'd0, 32'h11112222);
      finish_txn();
      chk("one_done", done_cnt - d0, 1);

      // arready backpressure
      fetch(32'h9FC00010);
      ar_q.push_back('{4'd0, 32'h1FC00010, 3'd2});
      exp_i = 32'h01234567;
      done_q.push_back('{exp_i, exp_d});
      ar_accept(10);
      r_beat(4'd0, 32'h01234567);
      finish_txn();

      // mismatched rid is ignored
      fetch(32'hBFC00020);
      ar_q.push_back('{4'd0, 32'h1FC00020, 3'd2});
      exp_i = 32'h0000CAFE;
      done_q.push_back('{exp_i, exp_d});
      ar_accept(1);
      r_beat(4'd1, 32'hBAD0BAD0);
      chk("badrid_stall", {31'd0, stallreq}, 1);
      r_beat(4'd0, 32'h0000CAFE);
      finish_txn();

      // byte store, awready three cycles ahead of wready
      store(32'hA0000002, 4'b0100, 32'h00AB0000);
      aw_q.push_back('{4'd1, 32'h00000002, 3'd0});
      w_q.push_back('{32'h00AB0000, 4'b0100});
      done_q.push_back('{exp_i, exp_d});
      wr_accept(0, 3);
      b_resp();
      finish_txn();

      // halfword store, wready first
      store(32'h00000102, 4'b1100, 32'h5A5A0000);
      aw_q.push_back('{4'd1, 32'h00000102, 3'd1});
      w_q.push_back('{32'h5A5A0000, 4'b1100});
      done_q.push_back('{exp_i, exp_d});
      wr_accept(2, 0);
      b_resp();
      finish_txn();

      // word store + fetch, reset while waiting on B
      store(32'h80000010, 4'b1111, 32'hCAFEF00D);
      fetch(32'hBFC00030);
      aw_q.push_back('{4'd1, 32'h00000010, 3'd2});
      w_q.push_back('{32'hCAFEF00D, 4'b1111});
      wr_accept(0, 0);
      wait_for(3, "bready_before_reset");
      rst = 1'b0;
      #1;
      chk("rst_mid_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 0);
      chk("rst_mid_stall", {31'd0, stallreq}, 0);
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      data_sram_wen = 4'd0;
      step();
      rst = 1'b1;
      step();
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
      step();
      chk("post_b_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 0);
      chk("post_b_stall", {31'd0, stallreq}, 0);
      chk("post_rst_drdata", data_sram_rdata, 0);
      chk("post_rst_irdata", inst_sram_rdata, 0);

      chk("ar_q_empty", ar_q.size(), 0);
      chk("aw_q_empty", aw_q.size(), 0);
      chk("w_q_empty", w_q.size(), 0);
      chk("done_q_empty", done_q.size(), 0);
      chk("done_total", done_cnt, 6);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core. Converts the core's two single-cycle SRAM-style ports (instruction fetch and data load/store) into one AXI3-subset master port.
- Serves at most one outstanding transaction at a time.
- Raises stallreq toward CTRL so the pipeline freezes until both of the current cycle's requests have completed.
- Data requests are served before instruction requests.

Parameters:
- INST_ID, 4'd0, arid used for instruction reads
- DATA_ID, 4'd1, arid/awid used for data accesses
- MAP_KSEG, 1, when 1: addr[31:29] of 3'b100 or 3'b101 is replaced by 3'b000 (kseg0/kseg1 to physical); when 0: address passed through

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- inst_sram_en  in  1  instruction read request
- inst_sram_addr  in  32  fetch address
- inst_sram_rdata  out  32  fetched instruction
- data_sram_en  in  1  data access request
- data_sram_wen  in  4  byte write enables; 0 means read
- data_sram_addr  in  32  data address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  load data
- stallreq  out  1  pipeline stall request to CTRL
- arid/araddr/arsize/arvalid  out  4/32/3/1  read address channel; arlen=0, arburst=INCR (tied)
- arready  in  1
- rid/rdata/rvalid  in  4/32/1  read data channel
- rready  out  1
- awid/awaddr/awsize/awvalid  out  4/32/3/1  write address channel; awlen=0 (tied)
- awready  in  1
- wdata/wstrb/wvalid/wlast  out  32/4/1/1  write data channel; wlast=1 (tied)
- wready  in  1
- bvalid  in  1  write response valid
- bready  out  1  write response ready

Behaviour:
- Reset (rst low, async): state=IDLE; all valid/ready outputs 0; rdata registers 0; pending flags 0; stallreq 0.
- States:
  - IDLE
  - D_AR, D_R (data read)
  - D_AW (aw+w issue), D_B (write response)
  - I_AR, I_R (instruction read)
  - DONE
- IDLE:
  - With any en set: latch addr/wdata/wen and set pend_d=data_sram_en, pend_i=inst_sram_en.
  - Go to D_AW if pend_d and wen!=0; else D_AR if pend_d; else I_AR.
  - stallreq is combinationally 1 in this cycle.
- stallreq = 1 in every state except DONE, and in IDLE when no en is set.
- D_AR/I_AR:
  - arvalid=1 with the latched address; hold until arready.
  - arsize=2 for reads, aligned word address.
  - Then go to D_R/I_R.
- D_R/I_R:
  - rready=1.
  - On rvalid with the matching rid: capture rdata into the data or inst rdata register and clear the pend flag.
  - Next state: I_AR if pend_i is still set, else DONE.
  - An rvalid with a mismatched rid is ignored.
- D_AW:
  - awvalid and wvalid asserted together; each drops independently on its own ready.
  - Leave D_AW only once both handshakes are done (same or different cycles) → D_B.
- D_B: bready=1; on bvalid clear pend_d, then go to I_AR if pend_i, else DONE.
- DONE (one cycle):
  - stallreq=0 so the pipeline advances; rdata outputs hold their captured values. Return to IDLE.
- rdata outputs change only on capture and stay stable otherwise, including across stalls.
- awsize from wen:
  - 1111 → 2
  - 0011 or 1100 → 1
  - single bit → 0
  - wstrb=wen; awaddr keeps the low address bits.
- AXI rule: a valid, once raised, stays high with stable payload until its ready, regardless of core inputs.
- Reset mid-transaction: all state clears immediately. A response arriving after reset is ignored because all ready outputs are 0.

Test Plan:
- Inst-only: inst_en=1, addr=0xBFC00000; arready on cycle 2; rvalid rid=0 rdata=0x3C1D0001 → araddr=0x1FC00000, arid=0, stallreq high until DONE, inst_sram_rdata=0x3C1D0001.
- Load+fetch in the same cycle: data addr=0x80001000, inst addr=0xBFC00004 → data AR (arid=1, araddr=0x00001000) issued before inst AR; both rdata captured; exactly one DONE cycle.
- Byte store: wen=0100, addr=0xA0000002, wdata=0x00AB0000 → awsize=0, wstrb=0100, awaddr=0x00000002; awready arrives 3 cycles before wready; B accepted only after both; then DONE.
- Backpressure: arready held low for 10 cycles → arvalid and araddr stable throughout; stallreq stays 1.
- Wrong rid: rvalid with rid=1 while in I_R → ignored; the subsequent rid=0 beat is captured.
- Async reset asserted in D_B → all valid/ready/stallreq go 0 immediately; a later bvalid causes no state change.
